// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-port, fixed-latency memory between the
// instruction-fetch port (I, read only) and the MEM-stage data port (D).
// Each access walks IDLE -> ISSUE -> WAIT -> RESP and ends with a one-cycle ack.
//
// Handshake: a requester raises req together with its address (and, for D,
// we/wdata) and holds all of them stable until it sees ack=1 for one cycle.
// Requests are only sampled in IDLE, so a req still high after ack starts a
// fresh access at the next IDLE instead of being issued twice. stall tells the
// pipeline that some request is outstanding and not yet acknowledged.
module pipe_mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          stall,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_t     state;
  owner_t     owner;
  logic [3:0] cnt;
  logic       cap_we;

  // Pending-request view for the pipeline; deliberately independent of state.
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  // Expose the FSM state for debug and checkers.
  assign dbg_state = state;

  // Arbitration and access sequencing. m_addr/m_wdata double as the captured
  // request, so they simply hold their last value outside ISSUE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_NONE;
      cnt     <= 4'd0;
      cap_we  <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          // D wins ties: the MEM-stage instruction is older than the fetch.
          if (d_req) begin
            owner   <= OWN_D;
            cap_we  <= d_we;
            m_en    <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            state   <= ISSUE;
          end else if (i_req) begin
            owner   <= OWN_I;
            cap_we  <= 1'b0;
            m_en    <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          m_en  <= 1'b0;
          m_we  <= 1'b0;
          cnt   <= LAT4;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // cnt==1 is exactly MEM_LAT cycles after the m_en cycle.
          if (cnt == 4'd1) begin
            if (owner == OWN_I) begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end else begin
              if (!cap_we) d_rdata <= m_rdata;
              d_ack <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Testbench for pipe_mem_arbiter: directed accesses against a latency-2 memory
// model, plus a MEM_LAT=1 instance for the single-fetch latency check.
module tb_pipe_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT (MEM_LAT=2) ----------------
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_ack, d_ack, m_en, m_we, stall;
  logic [1:0]  dbg_state;

  pipe_mem_arbiter #(.MEM_LAT(2), .AW(32), .DW(32)) u_dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .stall(stall), .dbg_state(dbg_state)
  );

  // ---------------- DUT (MEM_LAT=1) ----------------
  logic        i_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [31:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic        i_ack1, d_ack1, m_en1, m_we1, stall1;
  logic [1:0]  dbg_state1;

  pipe_mem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_dut1 (
    .clock(clock), .reset(reset),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata1), .stall(stall1), .dbg_state(dbg_state1)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem [0:255];
  logic [31:0] dly [0:15];
  logic [31:0] last_wr_addr = '0, last_wr_data = '0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h8C01_0004;  // 0x40
    mem[8'h40] = 32'h0000_0011;  // 0x100
    mem[8'h00] = 32'h0000_00A0;  // 0x0
    mem[8'h01] = 32'h0000_00A4;  // 0x4
    mem[8'h02] = 32'h0000_00A8;  // 0x8
  end

  // Read data appears MEM_LAT cycles after the m_en cycle; garbage otherwise.
  always @(posedge clock) begin
    if (m_en && m_we) begin
      last_wr_addr <= m_addr;
      last_wr_data <= m_wdata;
    end
    dly[0] <= m_en ? mem[m_addr[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < 16; i++) dly[i] <= dly[i-1];
  end
  assign m_rdata = dly[1];

  always @(posedge clock)
    m_rdata1 <= m_en1 ? mem[m_addr1[9:2]] : 32'hBAD1_BAD1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // ack entry: {is_d, cycle[15:0], data[31:0]}
  logic [48:0] ack_q[$];
  // m_en entry: {check_wdata, cycle[15:0], we, addr[31:0], wdata[31:0]}
  logic [81:0] men_q[$];
  logic [48:0] ack_e;
  logic [81:0] men_e;
  logic [31:0] ack_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_ack(input bit is_d, input int c, input logic [31:0] d);
    ack_q.push_back({is_d, 16'(c), d});
  endtask

  task automatic exp_men(input bit chk_wd, input int c, input bit we,
                         input logic [31:0] a, input logic [31:0] wd);
    men_q.push_back({chk_wd, 16'(c), we, a, wd});
  endtask

  // Monitor: pops an expectation whenever the DUT acks or strobes memory.
  always @(negedge clock) begin
    if (i_ack || d_ack) begin
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected cyc=%0d i_ack=%0b d_ack=%0b", cyc, i_ack, d_ack);
      end else begin
        ack_e    = ack_q.pop_front();
        ack_data = ack_e[48] ? d_rdata : i_rdata;
        if ((i_ack && d_ack) || (d_ack != ack_e[48]) ||
            (cyc != int'(ack_e[47:32])) || (ack_data !== ack_e[31:0])) begin
          errors++;
          $display("FAIL ack cyc=%0d d_ack=%0b data=%h exp: cyc=%0d d=%0b data=%h",
                   cyc, d_ack, ack_data, int'(ack_e[47:32]), ack_e[48], ack_e[31:0]);
        end
      end
    end
    if (m_en) begin
      checks++;
      if (men_q.size() == 0) begin
        errors++;
        $display("FAIL m_en_unexpected cyc=%0d addr=%h", cyc, m_addr);
      end else begin
        men_e = men_q.pop_front();
        if ((cyc != int'(men_e[80:65])) || (m_we !== men_e[64]) ||
            (m_addr !== men_e[63:32]) || (men_e[81] && (m_wdata !== men_e[31:0]))) begin
          errors++;
          $display("FAIL m_en cyc=%0d we=%0b addr=%h wdata=%h exp: cyc=%0d we=%0b addr=%h wdata=%h",
                   cyc, m_we, m_addr, m_wdata, int'(men_e[80:65]), men_e[64],
                   men_e[63:32], men_e[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  int t0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    @(negedge clock);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_m_en", 32'(m_en), 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: single fetch
    t0 = cyc;
    i_req = 1'b1; i_addr = 32'h40;
    exp_men(1'b0, t0 + 1, 1'b0, 32'h40, 32'h0);
    exp_ack(1'b0, t0 + 4, 32'h8C01_0004);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) i_req = 1'b0;
      @(negedge clock);
      if (k < 5) check("t1_stall", 32'(stall), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end

    // 2: contention, D wins
    t0 = cyc;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    exp_men(1'b0, t0 + 1, 1'b0, 32'h100, 32'h0);
    exp_ack(1'b1, t0 + 4, 32'h11);
    exp_men(1'b0, t0 + 6, 1'b0, 32'h40, 32'h0);
    exp_ack(1'b0, t0 + 9, 32'h8C01_0004);
    for (int k = 0; k < 11; k++) begin
      if (k == 5)  d_req = 1'b0;
      if (k == 10) i_req = 1'b0;
      @(negedge clock);
      if (k < 10) check("t2_stall", 32'(stall), (k < 9) ? 32'd1 : 32'd0);
      tick();
    end

    // 3: store; d_rdata keeps the last load value
    t0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    exp_men(1'b1, t0 + 1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    exp_ack(1'b1, t0 + 4, 32'h11);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin d_req = 1'b0; d_we = 1'b0; end
      @(negedge clock);
      tick();
    end
    check("t3_wr_addr", last_wr_addr, 32'h20);
    check("t3_wr_data", last_wr_data, 32'hDEAD_BEEF);

    // 4: reset mid-access
    t0 = cyc;
    i_req = 1'b1; i_addr = 32'h40;
    exp_men(1'b0, t0 + 1, 1'b0, 32'h40, 32'h0);
    tick();
    tick();
    reset = 1'b1; i_req = 1'b0;
    @(negedge clock);
    check("t4_m_en_c2", 32'(m_en), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("t4_state", 32'(dbg_state), 32'd0);
    check("t4_i_rdata", i_rdata, 32'h0);
    check("t4_d_rdata", d_rdata, 32'h0);
    check("t4_m_en", 32'(m_en), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clock);
      check("t4_no_ack", 32'(i_ack), 32'd0);
    end
    tick();

    // 5: back-to-back fetches with req held
    t0 = cyc;
    i_req = 1'b1; i_addr = 32'h0;
    exp_men(1'b0, t0 + 1,  1'b0, 32'h0, 32'h0);
    exp_ack(1'b0, t0 + 4,  32'hA0);
    exp_men(1'b0, t0 + 6,  1'b0, 32'h4, 32'h0);
    exp_ack(1'b0, t0 + 9,  32'hA4);
    exp_men(1'b0, t0 + 11, 1'b0, 32'h8, 32'h0);
    exp_ack(1'b0, t0 + 14, 32'hA8);
    for (int k = 0; k < 16; k++) begin
      if (k == 5)  i_addr = 32'h4;
      if (k == 10) i_addr = 32'h8;
      if (k == 15) i_req = 1'b0;
      @(negedge clock);
      tick();
    end

    // 6: MEM_LAT=1 instance, single fetch
    i_req1 = 1'b1; i_addr1 = 32'h40;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) i_req1 = 1'b0;
      @(negedge clock);
      check("t6_m_en", 32'(m_en1), (k == 1) ? 32'd1 : 32'd0);
      check("t6_i_ack", 32'(i_ack1), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) check("t6_i_rdata", i_rdata1, 32'h8C01_0004);
      if (k == 5) check("t6_idle", {28'd0, dbg_state1, d_ack1, stall1}, 32'd0);
      tick();
    end

    // Drain and report
    repeat (4) tick();
    check("ack_q_left", ack_q.size(), 32'd0);
    check("men_q_left", men_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
